// File: rtl/excp_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller:
// exception codes, CP0 addresses, vector and FSM encodings.
package excp_ctrl_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_INV  = 32'ha;
  localparam logic [31:0] EXC_TRAP = 32'hc;
  localparam logic [31:0] EXC_OV   = 32'hd;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  localparam int FL_SYS  = 8;
  localparam int FL_INV  = 9;
  localparam int FL_TRAP = 10;
  localparam int FL_OV   = 11;
  localparam int FL_ERET = 12;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FLUSH   = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  typedef struct packed {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
  } cp0_t;

endpackage

// File: rtl/excp_ctrl_if.sv
// MEM-stage exception bundle between the pipeline
// (master) and the exception controller (slave).
interface excp_ctrl_if;
  logic [31:0] excep_flags_i;
  logic [31:0] inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_wdata_i;
  logic        stall_i;
  logic [31:0] excep_type_o;
  logic [31:0] curr_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  modport master (
    output excep_flags_i, inst_addr_i, is_in_delayslot_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
    output stall_i,
    input  excep_type_o, curr_inst_addr_o, is_in_delayslot_o,
    input  flush_o, new_pc_o, busy_o
  );

  modport slave (
    input  excep_flags_i, inst_addr_i, is_in_delayslot_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
    input  stall_i,
    output excep_type_o, curr_inst_addr_o, is_in_delayslot_o,
    output flush_o, new_pc_o, busy_o
  );
endinterface

// File: rtl/excp_ctrl_bypass.sv
// Forwards the CP0 write in flight in WB onto the
// status/cause/epc values seen by the MEM stage.
module excp_bypass
  import excp_ctrl_pkg::*;
(
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [31:0] status,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  output cp0_t        cp0
);

  logic hit_status;
  logic hit_cause;
  logic hit_epc;

  assign hit_status = we && (waddr == CP0_STATUS);
  assign hit_cause  = we && (waddr == CP0_CAUSE);
  assign hit_epc    = we && (waddr == CP0_EPC);

  // only IP[1:0], IV and WP of cause are software-writable
  assign cp0.status = hit_status ? wdata : status;
  assign cp0.cause  = hit_cause
                    ? (cause & ~CAUSE_WMASK)
                      | (wdata & CAUSE_WMASK)
                    : cause;
  assign cp0.epc    = hit_epc ? wdata : epc;

endmodule

// File: rtl/excp_ctrl.sv
// MEM-stage exception arbiter: picks the winning event
// and sequences IDLE -> FLUSH -> RECOVER -> IDLE.
module excp_ctrl
  import excp_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  excp_ctrl_if.slave bus
);

  cp0_t        cp0;
  logic [1:0]  state;
  logic [31:0] type_q;
  logic [31:0] addr_q;
  logic        ds_q;
  logic [31:0] pc_q;
  logic        intr;
  logic [31:0] code;
  logic        take;
  logic [31:0] flags;

  excp_bypass u_bypass (
    .we     (bus.wb_cp0_we_i),
    .waddr  (bus.wb_cp0_waddr_i),
    .wdata  (bus.wb_cp0_wdata_i),
    .status (bus.cp0_status_i),
    .cause  (bus.cp0_cause_i),
    .epc    (bus.cp0_epc_i),
    .cp0    (cp0)
  );

  assign flags = bus.excep_flags_i;

  assign intr = (|(cp0.cause[15:8] & cp0.status[15:8]))
              && cp0.status[0]
              && !cp0.status[1];

  always_comb begin
    code = EXC_NONE;
    if (intr)                code = EXC_INT;
    else if (flags[FL_SYS])  code = EXC_SYS;
    else if (flags[FL_INV])  code = EXC_INV;
    else if (flags[FL_TRAP]) code = EXC_TRAP;
    else if (flags[FL_OV])   code = EXC_OV;
    else if (flags[FL_ERET]) code = EXC_ERET;
  end

  assign take = (state == S_IDLE)
              && (bus.inst_addr_i != 32'h0)
              && !bus.stall_i
              && (code != EXC_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      type_q <= EXC_NONE;
      addr_q <= 32'h0;
      ds_q   <= 1'b0;
      pc_q   <= 32'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (take) begin
            state  <= S_FLUSH;
            type_q <= code;
            addr_q <= bus.inst_addr_i;
            ds_q   <= bus.is_in_delayslot_i;
            pc_q   <= (code == EXC_ERET)
                    ? cp0.epc : EXC_VECTOR;
          end
        end
        S_FLUSH: begin
          state  <= S_RECOVER;
          type_q <= EXC_NONE;
          ds_q   <= 1'b0;
        end
        S_RECOVER: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign bus.excep_type_o      = type_q;
  assign bus.curr_inst_addr_o  = addr_q;
  assign bus.is_in_delayslot_o = ds_q;
  assign bus.new_pc_o          = pc_q;
  assign bus.flush_o           = (state == S_FLUSH);
  assign bus.busy_o            = (state != S_IDLE);

  logic unused_bits;
  assign unused_bits = ^{flags[31:13], flags[7:0],
                         cp0.status[31:16],
                         cp0.status[7:2],
                         cp0.cause[31:16],
                         cp0.cause[7:0]};

endmodule

// File: tb/tb_excp_ctrl.sv
// Randomised + directed bench for excp_ctrl against a
// cycle-level behavioural model of the exception rules.
module tb_excp_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  excp_ctrl_if bus ();

  excp_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          m_phase;
  logic [31:0] m_type;
  logic [31:0] m_addr;
  logic        m_ds;
  logic [31:0] m_pc;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] want_code();
    logic [31:0] st, ca;
    logic [31:0] f;
    st = bus.cp0_status_i;
    ca = bus.cp0_cause_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd12)
      st = bus.wb_cp0_wdata_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13) begin
      ca[9:8] = bus.wb_cp0_wdata_i[9:8];
      ca[22]  = bus.wb_cp0_wdata_i[22];
      ca[23]  = bus.wb_cp0_wdata_i[23];
    end
    f = bus.excep_flags_i;
    if (((ca[15:8] & st[15:8]) != 0) && st[0] && !st[1])
      return 32'h1;
    if (f[8])  return 32'h8;
    if (f[9])  return 32'ha;
    if (f[10]) return 32'hc;
    if (f[11]) return 32'hd;
    if (f[12]) return 32'he;
    return 32'h0;
  endfunction

  // phase counts cycles since capture: 0 idle, 1 flush, 2 recover
  task automatic model_step();
    logic [31:0] c;
    logic [31:0] epc;
    if (m_phase == 1) begin
      m_phase = 2;
      m_type = 0;
      m_ds = 0;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else begin
      c = want_code();
      if (c != 0 && bus.inst_addr_i != 0 && !bus.stall_i) begin
        epc = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd14)
            ? bus.wb_cp0_wdata_i : bus.cp0_epc_i;
        m_phase = 1;
        m_type = c;
        m_addr = bus.inst_addr_i;
        m_ds = bus.is_in_delayslot_i;
        m_pc = (c == 32'he) ? epc : 32'h20;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_type = 0;
      m_addr = 0;
      m_ds = 0;
      m_pc = 0;
    end else begin
      model_step();
    end
    #1;
    chk("type", bus.excep_type_o, m_type);
    chk("addr", bus.curr_inst_addr_o, m_addr);
    chk("ds", {31'b0, bus.is_in_delayslot_o}, {31'b0, m_ds});
    chk("flush", {31'b0, bus.flush_o},
        {31'b0, m_phase == 1});
    chk("new_pc", bus.new_pc_o, m_pc);
    chk("busy", {31'b0, bus.busy_o},
        {31'b0, m_phase != 0});
  end

  task automatic clear();
    bus.excep_flags_i = 0;
    bus.inst_addr_i = 0;
    bus.is_in_delayslot_i = 0;
    bus.cp0_status_i = 0;
    bus.cp0_cause_i = 0;
    bus.cp0_epc_i = 0;
    bus.wb_cp0_we_i = 0;
    bus.wb_cp0_waddr_i = 0;
    bus.wb_cp0_wdata_i = 0;
    bus.stall_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int nflush;

  initial begin
    clear();
    step();
    step();
    chk("rst_type", bus.excep_type_o, 32'h0);
    chk("rst_busy", {31'b0, bus.busy_o}, 32'h0);
    rst_n = 1'b1;

    // first qualifying edge after reset: syscall
    bus.excep_flags_i = 32'h100;
    bus.inst_addr_i = 32'h100;
    step();
    chk("sys_type", bus.excep_type_o, 32'h8);
    chk("sys_addr", bus.curr_inst_addr_o, 32'h100);
    chk("sys_flush", {31'b0, bus.flush_o}, 32'h1);
    chk("sys_pc", bus.new_pc_o, 32'h20);
    clear();
    step();
    chk("sys_rec_flush", {31'b0, bus.flush_o}, 32'h0);
    chk("sys_rec_busy", {31'b0, bus.busy_o}, 32'h1);
    step();
    chk("sys_idle", {31'b0, bus.busy_o}, 32'h0);
    chk("sys_hold_pc", bus.new_pc_o, 32'h20);

    // eret with epc bypassed from WB
    bus.excep_flags_i = 32'h1000;
    bus.inst_addr_i = 32'h80;
    bus.is_in_delayslot_i = 1;
    bus.cp0_epc_i = 32'h200;
    bus.wb_cp0_we_i = 1;
    bus.wb_cp0_waddr_i = 5'd14;
    bus.wb_cp0_wdata_i = 32'h300;
    step();
    chk("eret_type", bus.excep_type_o, 32'he);
    chk("eret_pc", bus.new_pc_o, 32'h300);
    chk("eret_ds", {31'b0, bus.is_in_delayslot_o}, 32'h1);
    clear();
    step();
    step();

    // interrupt beats overflow
    bus.cp0_status_i = 32'h0000_FF01;
    bus.cp0_cause_i = 32'h400;
    bus.excep_flags_i = 32'h800;
    bus.inst_addr_i = 32'h40;
    step();
    chk("intr_type", bus.excep_type_o, 32'h1);
    bus.excep_flags_i = 0;
    step();
    step();
    // EXL set masks the interrupt
    bus.cp0_status_i = 32'h0000_FF03;
    bus.excep_flags_i = 32'h800;
    step();
    chk("ov_type", bus.excep_type_o, 32'hd);
    clear();
    step();
    step();

    // trap held off by stall
    bus.excep_flags_i = 32'h400;
    bus.inst_addr_i = 32'h60;
    bus.stall_i = 1;
    nflush = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nflush += int'(bus.flush_o);
    end
    chk("stall_noflush", nflush, 0);
    bus.stall_i = 0;
    step();
    chk("trap_type", bus.excep_type_o, 32'hc);
    nflush += int'(bus.flush_o);
    clear();
    for (int i = 0; i < 3; i++) begin
      step();
      nflush += int'(bus.flush_o);
    end
    chk("trap_one_flush", nflush, 1);

    // back-to-back syscalls: second lands in FLUSH/RECOVER
    bus.excep_flags_i = 32'h100;
    bus.inst_addr_i = 32'h100;
    step();
    chk("b2b_first", {31'b0, bus.flush_o}, 32'h1);
    bus.inst_addr_i = 32'h104;
    step();
    chk("b2b_rec", {31'b0, bus.flush_o}, 32'h0);
    chk("b2b_rec_type", bus.excep_type_o, 32'h0);
    clear();
    step();
    chk("b2b_idle", {31'b0, bus.busy_o}, 32'h0);
    step();
    chk("b2b_noflush", {31'b0, bus.flush_o}, 32'h0);
    chk("b2b_addr", bus.curr_inst_addr_o, 32'h100);

    // async reset while in FLUSH
    bus.excep_flags_i = 32'h100;
    bus.inst_addr_i = 32'h500;
    step();
    chk("pre_rst_flush", {31'b0, bus.flush_o}, 32'h1);
    clear();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_flush", {31'b0, bus.flush_o}, 32'h0);
    chk("arst_busy", {31'b0, bus.busy_o}, 32'h0);
    chk("arst_type", bus.excep_type_o, 32'h0);
    chk("arst_addr", bus.curr_inst_addr_o, 32'h0);
    step();
    rst_n = 1'b1;
    bus.excep_flags_i = 32'h200;
    bus.inst_addr_i = 32'h44;
    step();
    chk("post_rst_type", bus.excep_type_o, 32'ha);
    clear();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] f;
      f = $urandom & 32'hFFFF_E0FF;
      for (int b = 8; b <= 12; b++)
        if ($urandom_range(0, 7) == 0) f[b] = 1'b1;
      bus.excep_flags_i = f;
      bus.inst_addr_i = ($urandom_range(0, 4) == 0)
                      ? 32'h0 : $urandom;
      bus.is_in_delayslot_i = 1'($urandom_range(0, 1));
      bus.cp0_status_i = $urandom & 32'hFFFF_FF03;
      bus.cp0_cause_i = ($urandom_range(0, 3) == 0)
                      ? $urandom : ($urandom & 32'hFFFF_00FF);
      bus.cp0_epc_i = $urandom;
      bus.wb_cp0_we_i = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: bus.wb_cp0_waddr_i = 5'd12;
        1: bus.wb_cp0_waddr_i = 5'd13;
        2: bus.wb_cp0_waddr_i = 5'd14;
        default: bus.wb_cp0_waddr_i = 5'($urandom);
      endcase
      bus.wb_cp0_wdata_i = $urandom;
      bus.stall_i = ($urandom_range(0, 3) == 0);
      step();
    end
    clear();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/excp_ctrl.md
EXCP_CTRL -- requirements
Module: excp_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port excep_flags_i, input, 32, MEM-stage flags: [8] syscall, [9] invalid inst, [10] trap, [11] overflow, [12] eret.
REQ-004 SHALL have port inst_addr_i, input, 32, MEM-stage instruction address; 0 marks a bubble.
REQ-005 SHALL have port is_in_delayslot_i, input, 1, MEM instruction is in a delay slot.
REQ-006 SHALL have ports cp0_status_i, cp0_cause_i, cp0_epc_i, input, 32 each, current CP0 register values.
REQ-007 SHALL have ports wb_cp0_we_i (1), wb_cp0_waddr_i (5), wb_cp0_wdata_i (32), input, the CP0 write in flight in WB.
REQ-008 SHALL have port stall_i, input, 1, MEM stage is stalled.
REQ-009 SHALL have port excep_type_o, output, 32, registered exception code to CP0: 0x1 intr, 0x8 syscall, 0xa invalid, 0xc trap, 0xd ov, 0xe eret, 0x0 none.
REQ-010 SHALL have ports curr_inst_addr_o (32) and is_in_delayslot_o (1), output, registered with excep_type_o.
REQ-011 SHALL have ports flush_o (1) and new_pc_o (32), output, pipeline flush and redirect target.
REQ-012 SHALL have port busy_o, output, 1, high while the FSM is not IDLE.

Function
REQ-013 Bypassed status SHALL be wb_cp0_wdata_i when wb_cp0_we_i=1 and waddr=12, else cp0_status_i.
REQ-014 Bypassed cause SHALL be cp0_cause_i with bits [9:8], [22], [23] taken from wb_cp0_wdata_i when wb_cp0_we_i=1 and waddr=13.
REQ-015 Bypassed epc SHALL be wb_cp0_wdata_i when wb_cp0_we_i=1 and waddr=14, else cp0_epc_i.
REQ-016 Interrupt pending SHALL be (cause[15:8] & status[15:8]) != 0, with status[0]=1 and status[1]=0, all from bypassed values.
REQ-017 An event SHALL be considered only when inst_addr_i != 0, stall_i=0, and state=IDLE.
REQ-018 Priority SHALL be: interrupt > syscall > invalid > trap > overflow > eret; only the highest-priority event is taken.
REQ-019 FSM SHALL have states IDLE, FLUSH and RECOVER.
REQ-020 In IDLE with an event, the FSM SHALL go to FLUSH at the next edge, registering excep_type_o, curr_inst_addr_o, is_in_delayslot_o and new_pc_o.
REQ-021 new_pc_o SHALL be the bypassed epc for eret, else 0x00000020.
REQ-022 In FLUSH, flush_o SHALL be 1 for exactly one cycle, excep_type_o SHALL hold the code, then the FSM SHALL go to RECOVER.
REQ-023 In RECOVER, excep_type_o SHALL be 0, flush_o 0, inputs ignored (wrong-path instructions), then the FSM SHALL go to IDLE.
REQ-024 Outside FLUSH, excep_type_o, flush_o and is_in_delayslot_o SHALL be 0; curr_inst_addr_o and new_pc_o SHALL hold their last value.
REQ-025 Stall with a pending event SHALL defer capture until the first cycle with stall_i=0; nothing is lost or duplicated.
REQ-026 Simultaneous WB CP0 write and MEM event SHALL use bypassed values in that same cycle.

Reset
REQ-027 On rst_n=0 the FSM SHALL be IDLE and all outputs 0, immediately and asynchronously, including mid-FLUSH or mid-RECOVER.
REQ-028 After reset release, the first event SHALL be accepted on the first qualifying edge.

Structure
REQ-029 Exception codes, the 0x20 vector, CP0 addresses (12/13/14) and FSM state encodings SHALL live in the shared defines package.
REQ-030 A sub-module excp_bypass SHALL implement REQ-013..015 combinationally; excp_ctrl holds priority logic and FSM.

Verification
REQ-031 syscall flag, addr 0x100, delayslot=0 -> next edge excep_type_o=0x8, curr_inst_addr_o=0x100, flush_o=1 one cycle, new_pc_o=0x20; then one RECOVER cycle, then IDLE.
REQ-032 eret, cp0_epc_i=0x200, WB writes epc=0x300 same cycle -> excep_type_o=0xe, new_pc_o=0x300.
REQ-033 status=0x0000FF01, cause[10]=1, overflow flag at addr 0x40 -> excep_type_o=0x1 (interrupt wins); with status[1]=1 -> 0xd.
REQ-034 trap flag with stall_i=1 for 3 cycles -> no flush for those cycles; exactly one flush with 0xc after stall_i falls.
REQ-035 Two back-to-back syscalls -> second ignored during RECOVER, no second flush.
REQ-036 rst_n low during FLUSH -> flush_o, busy_o and excep_type_o go 0 without waiting for a clock edge.
